mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 selector: steps the select lines through channels 0..3,
// holding each for DWELL cycles, and publishes the four captured bits atomically.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       continuous_i,
  input  logic       result_i,
  output logic       sel0_o,
  output logic       sel1_o,
  output logic [3:0] sample_o,
  output logic       valid_o,
  output logic       busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [7:0] LastCnt = 8'(DWELL - 1);

  state_t      state_q;
  logic [1:0]  ch_q;
  logic [7:0]  cnt_q;
  logic [2:0]  shadow_q;
  logic [3:0]  sample_q;
  logic        valid_q;
  logic        busy_q;

  // Stop outranks both Start and a capture edge, so it is tested first in SCAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 3'd0;
      sample_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ch_q  <= 2'd0;
          cnt_q <= 8'd0;
          if (start_i && !stop_i) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (stop_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            ch_q     <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 3'd0;
          end else if (cnt_q == LastCnt) begin
            cnt_q <= 8'd0;
            if (ch_q == 2'd3) begin
              sample_q <= {result_i, shadow_q};
              valid_q  <= 1'b1;
              ch_q     <= 2'd0;
              if (!continuous_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              shadow_q[ch_q] <= result_i;
              ch_q           <= ch_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel0_o   = ch_q[0];
  assign sel1_o   = ch_q[1];
  assign sample_o = sample_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;

endmodule
